// File: rtl/icache_dm_if.sv
// rtl/icache_dm_if.sv - fetch and refill bus bundle for icache_dm
// master drives requests/refill data, slave is the cache.
interface icache_dm_if;
  logic         inst_read;
  logic [31:0]  inst_addr;
  logic [31:0]  inst_rdata;
  logic         inst_resp;
  logic         pmem_read;
  logic [31:0]  pmem_address;
  logic [255:0] pmem_rdata;
  logic         pmem_resp;

  modport slave (
    input  inst_read, inst_addr, pmem_rdata, pmem_resp,
    output inst_rdata, inst_resp, pmem_read, pmem_address
  );

  modport master (
    output inst_read, inst_addr, pmem_rdata, pmem_resp,
    input  inst_rdata, inst_resp, pmem_read, pmem_address
  );
endinterface

// File: rtl/icache_dm.sv
// rtl/icache_dm.sv - direct-mapped read-only instruction cache, 256-bit lines
// Define ICACHE_PERF_EN to add the hit_count/miss_count outputs.
module icache_dm #(
  parameter int S_INDEX = 3
) (
  input  logic        clk,
  input  logic        rst,
  icache_dm_if.slave  bus
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);
  localparam int TAG_W = 27 - S_INDEX;
  localparam int LINES = 1 << S_INDEX;

  typedef enum logic {CHECK, REFILL} state_e;

  state_e             state_q, state_d;
  logic [31:0]        miss_addr_q, miss_addr_d;
  logic [LINES-1:0]   valid_q;
  logic [TAG_W-1:0]   tag_q  [LINES];
  logic [255:0]       data_q [LINES];

  logic [TAG_W-1:0]   tag;
  logic [S_INDEX-1:0] idx;
  logic [2:0]         word;
  logic [TAG_W-1:0]   miss_tag;
  logic [S_INDEX-1:0] miss_idx;
  logic               hit;
  logic               unused_bits;

  assign tag      = bus.inst_addr[31:5+S_INDEX];
  assign idx      = bus.inst_addr[4+S_INDEX:5];
  assign word     = bus.inst_addr[4:2];
  assign miss_tag = miss_addr_q[31:5+S_INDEX];
  assign miss_idx = miss_addr_q[4+S_INDEX:5];
  assign hit      = bus.inst_read && valid_q[idx] && (tag_q[idx] == tag);
  assign unused_bits = ^{bus.inst_addr[1:0], miss_addr_q[4:0]};

  always_comb begin
    state_d          = state_q;
    miss_addr_d      = miss_addr_q;
    bus.inst_resp    = 1'b0;
    bus.pmem_read    = 1'b0;
    bus.pmem_address = '0;
    bus.inst_rdata   = data_q[idx][{word, 5'b0} +: 32];
    case (state_q)
      CHECK: begin
        bus.inst_resp = hit;
        if (bus.inst_read && !hit) begin
          state_d     = REFILL;
          miss_addr_d = {bus.inst_addr[31:5], 5'b0};
        end
      end
      REFILL: begin
        // Refill always completes to the latched line, whatever inst_addr does now.
        bus.pmem_read    = 1'b1;
        bus.pmem_address = miss_addr_q;
        if (bus.pmem_resp) state_d = CHECK;
      end
      default: state_d = CHECK;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= CHECK;
      miss_addr_q <= '0;
      valid_q     <= '0;
    end else begin
      state_q     <= state_d;
      miss_addr_q <= miss_addr_d;
      if (state_q == REFILL && bus.pmem_resp) valid_q[miss_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && state_q == REFILL && bus.pmem_resp) begin
      data_q[miss_idx] <= bus.pmem_rdata;
      tag_q[miss_idx]  <= miss_tag;
    end
  end

`ifdef ICACHE_PERF_EN
  logic [31:0] hit_count_q, miss_count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      if (state_q == CHECK && hit) hit_count_q <= hit_count_q + 32'd1;
      if (state_q == CHECK && state_d == REFILL) miss_count_q <= miss_count_q + 32'd1;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`endif
endmodule

// File: tb/tb_icache_dm.sv
// tb/tb_icache_dm.sv - directed bench for icache_dm
// Build with ICACHE_PERF_EN defined to also check the counters.
module tb_icache_dm;
  logic clk;
  logic rst;
  icache_dm_if bus ();
`ifdef ICACHE_PERF_EN
  logic [31:0] hit_count, miss_count;
`endif

  icache_dm dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef ICACHE_PERF_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] addr;
    logic        exp_resp;
    logic [31:0] exp_rdata;
    logic        exp_pmem_read;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] mk_line(input logic [31:0] base);
    logic [255:0] l;
    for (int k = 0; k < 8; k++) l[32*k +: 32] = base + 32'(k);
    return l;
  endfunction

  // Called just after an edge with the cache expected to be refilling; lat is cycles
  // from first pmem_read cycle to the pmem_resp cycle. Returns just after the resp edge.
  task automatic do_refill(input string name, input logic [31:0] exp_addr,
                           input logic [255:0] line, input int lat);
    int n;
    n = 0;
    while (!bus.pmem_read && n < 8) begin
      step();
      n++;
    end
    if (!bus.pmem_read) begin
      chk({name, "_pmem_read_timeout"}, 32'(bus.pmem_read), 32'd1);
      return;
    end
    chk({name, "_pmem_address"}, bus.pmem_address, exp_addr);
    for (int i = 1; i < lat; i++) step();
    bus.pmem_rdata = line;
    bus.pmem_resp  = 1'b1;
    step();
    bus.pmem_resp  = 1'b0;
    bus.pmem_rdata = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    for (int k = 0; k < 7; k++) begin
      vecs[k].addr          = 32'h64 + 32'(4 * k);
      vecs[k].exp_resp      = 1'b1;
      vecs[k].exp_rdata     = 32'h1000_0001 + 32'(k);
      vecs[k].exp_pmem_read = 1'b0;
    end

    rst = 1'b1;
    bus.inst_read  = 1'b0;
    bus.inst_addr  = '0;
    bus.pmem_rdata = '0;
    bus.pmem_resp  = 1'b0;
    step();
    step();
    @(negedge clk);
    chk("reset_pmem_read", 32'(bus.pmem_read), 32'd0);
    chk("reset_inst_resp", 32'(bus.inst_resp), 32'd0);
    chk("reset_pmem_address", bus.pmem_address, 32'd0);
`ifdef ICACHE_PERF_EN
    chk("reset_hit_count", hit_count, 32'd0);
    chk("reset_miss_count", miss_count, 32'd0);
`endif

    // Test 1: cold miss on 0x60, 3-cycle memory
    @(posedge clk); #1;
    rst = 1'b0;
    bus.inst_read = 1'b1;
    bus.inst_addr = 32'h60;
    @(negedge clk);
    chk("t1_miss_resp", 32'(bus.inst_resp), 32'd0);
    chk("t1_miss_pmem_read", 32'(bus.pmem_read), 32'd0);
    step();
    chk("t1_refill_pmem_read", 32'(bus.pmem_read), 32'd1);
    do_refill("t1", 32'h60, mk_line(32'h1000_0000), 3);
    @(negedge clk);
    chk("t1_hit_resp", 32'(bus.inst_resp), 32'd1);
    chk("t1_hit_rdata", bus.inst_rdata, 32'h1000_0000);
    chk("t1_hit_pmem_read", 32'(bus.pmem_read), 32'd0);
    step();

    // Test 2: sequential hits across the line
    for (int i = 0; i < 7; i++) begin
      bus.inst_addr = vecs[i].addr;
      @(negedge clk);
      chk($sformatf("t2_resp_%0d", i), 32'(bus.inst_resp), 32'(vecs[i].exp_resp));
      chk($sformatf("t2_rdata_%0d", i), bus.inst_rdata, vecs[i].exp_rdata);
      chk($sformatf("t2_pmem_read_%0d", i), 32'(bus.pmem_read), 32'(vecs[i].exp_pmem_read));
      step();
    end
    bus.inst_read = 1'b0;
    @(negedge clk);
    chk("idle_resp", 32'(bus.inst_resp), 32'd0);
    chk("idle_pmem_read", 32'(bus.pmem_read), 32'd0);
`ifdef ICACHE_PERF_EN
    chk("perf_hit_count", hit_count, 32'd8);
    chk("perf_miss_count", miss_count, 32'd1);
`endif
    step();

    // Test 3: conflict on index 0
    bus.inst_read = 1'b1;
    bus.inst_addr = 32'h0;
    @(negedge clk);
    chk("t3_a_miss", 32'(bus.inst_resp), 32'd0);
    step();
    do_refill("t3_a", 32'h0, mk_line(32'h2000_0000), 2);
    @(negedge clk);
    chk("t3_a_hit", 32'(bus.inst_resp), 32'd1);
    chk("t3_a_rdata", bus.inst_rdata, 32'h2000_0000);
    step();
    bus.inst_addr = 32'h100;
    @(negedge clk);
    chk("t3_b_miss", 32'(bus.inst_resp), 32'd0);
    step();
    do_refill("t3_b", 32'h100, mk_line(32'h3000_0000), 2);
    @(negedge clk);
    chk("t3_b_hit", 32'(bus.inst_resp), 32'd1);
    chk("t3_b_rdata", bus.inst_rdata, 32'h3000_0000);
    step();
    bus.inst_addr = 32'h0;
    @(negedge clk);
    chk("t3_a_remiss", 32'(bus.inst_resp), 32'd0);
    step();
    do_refill("t3_a2", 32'h0, mk_line(32'h2000_0000), 1);
    @(negedge clk);
    chk("t3_a2_rdata", bus.inst_rdata, 32'h2000_0000);
    step();

    // Test 4: address change during refill
    bus.inst_addr = 32'h40;
    @(negedge clk);
    chk("t4_miss40", 32'(bus.inst_resp), 32'd0);
    step();
    bus.inst_addr = 32'h80;
    do_refill("t4_40", 32'h40, mk_line(32'h4000_0000), 3);
    @(negedge clk);
    chk("t4_miss80", 32'(bus.inst_resp), 32'd0);
    step();
    do_refill("t4_80", 32'h80, mk_line(32'h5000_0000), 2);
    @(negedge clk);
    chk("t4_hit80", 32'(bus.inst_resp), 32'd1);
    chk("t4_rdata80", bus.inst_rdata, 32'h5000_0000);
    step();
    bus.inst_addr = 32'h44;
    @(negedge clk);
    chk("t4_hit44", 32'(bus.inst_resp), 32'd1);
    chk("t4_rdata44", bus.inst_rdata, 32'h4000_0001);
    step();

    // Test 5: reset mid-refill, late pmem_resp ignored
    bus.inst_addr = 32'h60;
    @(negedge clk);
    chk("t5_prehit60", 32'(bus.inst_resp), 32'd1);
    step();
    bus.inst_addr = 32'hA0;
    @(negedge clk);
    chk("t5_missA0", 32'(bus.inst_resp), 32'd0);
    step();
    chk("t5_refill_pmem_read", 32'(bus.pmem_read), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.inst_read  = 1'b0;
    bus.pmem_rdata = mk_line(32'hDEAD_0000);
    bus.pmem_resp  = 1'b1;
    @(negedge clk);
    chk("t5_post_rst_pmem_read", 32'(bus.pmem_read), 32'd0);
    chk("t5_post_rst_resp", 32'(bus.inst_resp), 32'd0);
    step();
    bus.pmem_resp  = 1'b0;
    bus.pmem_rdata = '0;
    @(negedge clk);
    chk("t5_late_resp_pmem_read", 32'(bus.pmem_read), 32'd0);
    step();
    bus.inst_read = 1'b1;
    bus.inst_addr = 32'h60;
    @(negedge clk);
    chk("t5_remiss60", 32'(bus.inst_resp), 32'd0);
    step();
    do_refill("t5_60", 32'h60, mk_line(32'h6000_0000), 1);
    @(negedge clk);
    chk("t5_hit60_rdata", bus.inst_rdata, 32'h6000_0000);
    step();
    bus.inst_read = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
